// File: rtl/pool_multi_core_ctrl_if.sv
// ---------------------------------------------------------------------------
// pool_multi_core_ctrl_if
//
// Purpose: groups the run-control handshake and the shared BRAM read/write
// buses of pool_multi_core_ctrl into one bundle.
//
// Signals:
//   start, mode, in_dim, channels : run request and per-run configuration
//   busy, done                    : run status (done is a one-cycle pulse)
//   pass_idx                      : current channel group (BRAM bank select)
//   rd_addr / rd_data             : shared read address, per-lane read data
//                                   (data valid one cycle after the address)
//   wr_en / wr_addr / wr_data     : per-lane write strobes, shared write
//                                   address, per-lane pooled results
//   dbg_state                     : controller FSM state, for observation
//
// Handshake: start is a one-cycle request and is only honoured while busy is
// low; the run ends with a single-cycle done pulse, after which busy drops.
//
// Modports: master = top-level sequencer plus BRAM side, slave = controller.
// ---------------------------------------------------------------------------
interface pool_multi_core_ctrl_if #(
    parameter int LANES      = 4,
    parameter int DATA_W     = 16,
    parameter int IN_ADDR_W  = 13,
    parameter int OUT_ADDR_W = 11,
    parameter int DIM_W      = 7,
    parameter int CH_W       = 6
);
    logic                    start;
    logic                    mode;
    logic [DIM_W-1:0]        in_dim;
    logic [CH_W-1:0]         channels;
    logic                    busy;
    logic                    done;
    logic [CH_W-1:0]         pass_idx;
    logic [IN_ADDR_W-1:0]    rd_addr;
    logic [LANES*DATA_W-1:0] rd_data;
    logic [LANES-1:0]        wr_en;
    logic [OUT_ADDR_W-1:0]   wr_addr;
    logic [LANES*DATA_W-1:0] wr_data;
    logic [3:0]              dbg_state;

    modport master (
        output start, mode, in_dim, channels, rd_data,
        input  busy, done, pass_idx, rd_addr, wr_en, wr_addr, wr_data, dbg_state
    );

    modport slave (
        input  start, mode, in_dim, channels, rd_data,
        output busy, done, pass_idx, rd_addr, wr_en, wr_addr, wr_data, dbg_state
    );
endinterface

// File: rtl/pool_multi_core_ctrl.sv
// ---------------------------------------------------------------------------
// pool_multi_core_ctrl
//
// Purpose: 2x2 / stride-2 average or max pooling over a square feature map,
// LANES channels at a time. The block walks every output pixel of every
// channel group (pass) itself and masks unused lanes in the last pass.
// Each output pixel takes 7 cycles: R0..R3 issue the four window addresses,
// R1..LAST capture the returning samples, WR strobes the result, NEXT steps.
//
// Ports:
//   clk   : clock
//   reset : asynchronous, active-low reset; aborts any run in progress
//   bus   : pool_multi_core_ctrl_if.slave (control handshake + BRAM buses)
//
// Build option: define POOL_AVG_ROUND_EN to round average results half
// toward +infinity ((sum + 2) >>> 2); otherwise averages floor (sum >>> 2).
// ---------------------------------------------------------------------------
module pool_multi_core_ctrl #(
    parameter int LANES      = 4,
    parameter int DATA_W     = 16,
    parameter int IN_ADDR_W  = 13,
    parameter int OUT_ADDR_W = 11,
    parameter int DIM_W      = 7,
    parameter int CH_W       = 6
) (
    input logic                  clk,
    input logic                  reset,
    pool_multi_core_ctrl_if.slave bus
);
    // Sum of four DATA_W samples fits in DATA_W+2 bits.
    localparam int ACC_W = DATA_W + 2;
    // Wide enough for channels + LANES - 1 without wrapping.
    localparam int PW    = CH_W + $clog2(LANES) + 1;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_R0   = 4'd1;
    localparam logic [3:0] S_R1   = 4'd2;
    localparam logic [3:0] S_R2   = 4'd3;
    localparam logic [3:0] S_R3   = 4'd4;
    localparam logic [3:0] S_LAST = 4'd5;
    localparam logic [3:0] S_WR   = 4'd6;
    localparam logic [3:0] S_NEXT = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    logic [3:0]            state_q,    state_d;
    logic                  mode_q,     mode_d;
    logic [DIM_W-1:0]      in_dim_q,   in_dim_d;
    logic [CH_W-1:0]       chan_q,     chan_d;
    logic [DIM_W-1:0]      out_dim_q,  out_dim_d;
    logic [CH_W-1:0]       passes_q,   passes_d;
    logic [CH_W-1:0]       pass_idx_q, pass_idx_d;
    logic [DIM_W-1:0]      row_q,      row_d;
    logic [DIM_W-1:0]      col_q,      col_d;
    // Address of the window's top-left row start: 2*row*in_dim, kept
    // incrementally so no multiplier is needed.
    logic [IN_ADDR_W-1:0]  row_base_q, row_base_d;
    logic [OUT_ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] acc_d [LANES];

    logic signed [ACC_W-1:0] sample_ext [LANES];
    logic signed [ACC_W-1:0] avg_sum    [LANES];
    logic [DATA_W-1:0]       lane_res   [LANES];
    logic [LANES-1:0]        lane_active;
    logic [PW-1:0]           ch_round;
    logic                    last_col;
    logic                    last_row;
    logic [IN_ADDR_W-1:0]    row_off;
    logic [IN_ADDR_W-1:0]    col_off;

    assign ch_round = PW'(bus.channels) + PW'(LANES - 1);
    assign last_col = (col_q == out_dim_q - DIM_W'(1));
    assign last_row = (row_q == out_dim_q - DIM_W'(1));

    // Per-lane sample extension, result formation and lane masking.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sample_ext[i] = ACC_W'(signed'(bus.rd_data[i*DATA_W +: DATA_W]));
`ifdef POOL_AVG_ROUND_EN
            avg_sum[i] = acc_q[i] + ACC_W'(2);
`else
            avg_sum[i] = acc_q[i];
`endif
            lane_res[i] = mode_q ? DATA_W'(acc_q[i]) : DATA_W'(avg_sum[i] >>> 2);
            lane_active[i] = ((32'(pass_idx_q) * 32'(LANES) + 32'(i)) < 32'(chan_q));
        end
    end

    // Read address: R1/R3 step one column right, R2/R3 step one row down.
    always_comb begin
        row_off     = ((state_q == S_R2) || (state_q == S_R3)) ? IN_ADDR_W'(in_dim_q) : '0;
        col_off     = ((state_q == S_R1) || (state_q == S_R3)) ? IN_ADDR_W'(1) : '0;
        bus.rd_addr = '0;
        if ((state_q == S_R0) || (state_q == S_R1) || (state_q == S_R2) || (state_q == S_R3)) begin
            bus.rd_addr = row_base_q + row_off + IN_ADDR_W'({col_q, 1'b0}) + col_off;
        end
    end

    // Write bus and status outputs, decoded from registered state.
    always_comb begin
        bus.wr_en   = (state_q == S_WR) ? lane_active : '0;
        bus.wr_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if ((state_q == S_WR) && lane_active[i]) begin
                bus.wr_data[i*DATA_W +: DATA_W] = lane_res[i];
            end
        end
    end

    assign bus.wr_addr   = wr_addr_q;
    assign bus.pass_idx  = pass_idx_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.dbg_state = state_q;

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        in_dim_d   = in_dim_q;
        chan_d     = chan_q;
        out_dim_d  = out_dim_q;
        passes_d   = passes_q;
        pass_idx_d = pass_idx_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        wr_addr_d  = wr_addr_q;
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d     = bus.mode;
                    in_dim_d   = bus.in_dim;
                    chan_d     = bus.channels;
                    out_dim_d  = bus.in_dim >> 1;
                    passes_d   = CH_W'(ch_round / PW'(LANES));
                    pass_idx_d = '0;
                    row_d      = '0;
                    col_d      = '0;
                    row_base_d = '0;
                    wr_addr_d  = '0;
                    // Nothing to pool: finish without touching the BRAMs.
                    if ((bus.channels == '0) || (bus.in_dim < DIM_W'(2))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_R0;
                    end
                end
            end
            S_R0: state_d = S_R1;
            S_R1: begin
                // First sample of the window seeds the accumulator.
                for (int i = 0; i < LANES; i++) begin
                    acc_d[i] = sample_ext[i];
                end
                state_d = S_R2;
            end
            S_R2, S_R3, S_LAST: begin
                for (int i = 0; i < LANES; i++) begin
                    if (mode_q) begin
                        acc_d[i] = (sample_ext[i] > acc_q[i]) ? sample_ext[i] : acc_q[i];
                    end else begin
                        acc_d[i] = acc_q[i] + sample_ext[i];
                    end
                end
                state_d = (state_q == S_R2) ? S_R3 : ((state_q == S_R3) ? S_LAST : S_WR);
            end
            S_WR: state_d = S_NEXT;
            S_NEXT: begin
                state_d = S_R0;
                if (last_col) begin
                    col_d = '0;
                    if (last_row) begin
                        // End of pass: rewind the map, move to the next group.
                        row_d      = '0;
                        row_base_d = '0;
                        wr_addr_d  = '0;
                        pass_idx_d = pass_idx_q + CH_W'(1);
                        if ((pass_idx_q + CH_W'(1)) == passes_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        row_d      = row_q + DIM_W'(1);
                        row_base_d = row_base_q + IN_ADDR_W'({in_dim_q, 1'b0});
                        wr_addr_d  = wr_addr_q + OUT_ADDR_W'(1);
                    end
                end else begin
                    col_d     = col_q + DIM_W'(1);
                    wr_addr_d = wr_addr_q + OUT_ADDR_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            in_dim_q   <= '0;
            chan_q     <= '0;
            out_dim_q  <= '0;
            passes_q   <= '0;
            pass_idx_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            wr_addr_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            in_dim_q   <= in_dim_d;
            chan_q     <= chan_d;
            out_dim_q  <= out_dim_d;
            passes_q   <= passes_d;
            pass_idx_q <= pass_idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            wr_addr_q  <= wr_addr_d;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end
endmodule

// File: doc/pool_multi_core_ctrl.md
Name: pool_multi_core_ctrl

Overview:
- Parametrised successor to the fixed 4-core average-pool controller.
- Runs 2x2/stride-2 pooling (average or max, selected per run) over a runtime-configured square feature map and channel count, using LANES parallel lanes.
- Each lane reads its own channel BRAM. All lanes share one read address and one write address.
- The block sequences channel-group passes itself and masks unused lanes in the final partial pass. The top-level FSM drives it with a start/done handshake.

Parameters:
- LANES, 4, number of parallel pooling lanes (channels per pass).
- DATA_W, 16, signed sample width.
- IN_ADDR_W, 13, input BRAM address width.
- OUT_ADDR_W, 11, output BRAM address width.
- DIM_W, 7, width of the in_dim input.
- CH_W, 6, width of the channels, pass_idx and pass-count fields.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- mode  in  1  0 = average, 1 = max; latched at start.
- in_dim  in  DIM_W  input map width = height; latched at start.
- channels  in  CH_W  total channel count; latched at start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- pass_idx  out  CH_W  current channel group; the top level uses it to select the BRAM bank set.
- rd_addr  out  IN_ADDR_W  shared input read address.
- rd_data  in  LANES*DATA_W  lane i occupies bits [DATA_W*i +: DATA_W]; valid 1 cycle after rd_addr.
- wr_en  out  LANES  per-lane output write strobe.
- wr_addr  out  OUT_ADDR_W  shared output write address.
- wr_data  out  LANES*DATA_W  per-lane pooled result, same packing as rd_data.

Behaviour:
- Reset: all outputs 0 (busy, done, pass_idx, rd_addr, wr_en, wr_addr, wr_data); FSM to IDLE; accumulators cleared. A reset asserted mid-run aborts the run immediately; no further writes occur.
- Derived values, latched at start:
  - out_dim = in_dim >> 1. For odd in_dim the last row and column are dropped.
  - passes = ceil(channels / LANES).
- FSM states: IDLE, R0, R1, R2, R3, LAST, WR, NEXT, DONE.
- IDLE: on start, latch mode/in_dim/channels; clear pass_idx, output row/col and wr_addr; go to R0. If channels == 0 or in_dim < 2, go directly to DONE with no writes. start is ignored in every other state.
- R0..R3 issue one window address each, with rd_addr = row*in_dim + col:
  - R0: (2r, 2c)
  - R1: (2r, 2c+1)
  - R2: (2r+1, 2c)
  - R3: (2r+1, 2c+1)
- Data capture: rd_data is captured in the cycle after each issue, i.e. in states R1, R2, R3 and LAST.
  - Average mode: signed accumulate in a DATA_W+2-bit accumulator.
  - Max mode: running signed maximum.
  - The first sample (captured in R1) initialises the accumulator.
- WR: wr_en[i] = 1 for every active lane, for exactly one cycle.
  - wr_data: average = sum >>> 2 (arithmetic shift, floor), truncated to DATA_W; max = the maximum.
  - wr_addr = r*out_dim + c.
- Lane masking: lane i is active iff pass_idx*LANES + i < channels. Inactive lanes have wr_en = 0 and wr_data = 0.
- NEXT: increment c, wrapping to 0 and incrementing r; increment wr_addr, which clears when the pass ends.
  - After the last pixel of a pass: increment pass_idx.
  - Then go to DONE if pass_idx reaches passes, else go to R0.
- DONE: done = 1 for one cycle, then IDLE. busy is 0 from the IDLE cycle onward.
- Latency: 7 cycles per output pixel (R0..NEXT). A run takes passes*out_dim^2*7 + 2 cycles, start to done inclusive.
- Arithmetic: results never saturate. The sum of four DATA_W values cannot overflow the DATA_W+2-bit accumulator.

Optional Feature:
- Macro POOL_AVG_ROUND_EN.
- Defined: average result = (sum + 2) >>> 2, i.e. round half toward +infinity.
- Undefined: floor, (sum >>> 2).
- Max mode is unaffected either way.

Test Plan:
- in_dim=4, channels=4, mode=avg; every lane's BRAM holds data = address.
  -> Write addr 0 data 2 on all lanes (window 0,1,4,5, sum 10; 3 with POOL_AVG_ROUND_EN).
  -> Write addr 3 data 12 (window 10,11,14,15).
  -> done 30 cycles after start.
- Same stimulus with mode=max -> writes at addrs 0..3 with data 5, 7, 13, 15.
- channels=6, LANES=4, in_dim=2.
  -> pass_idx 0: wr_en=4'b1111.
  -> pass_idx 1: wr_en=4'b0011.
  -> Exactly 2 write strobes in total, then done.
- Window {-1,-2,-3,-4}, average -> wr_data = -3 (-2 with POOL_AVG_ROUND_EN). Same window, max -> -1.
- in_dim=5 -> out_dim 2; rd_addr never touches row 4 or column 4. Also: channels=0 -> done 2 cycles after start, no wr_en.
- Assert reset during R2 of the second pixel -> all outputs 0 next cycle, no further wr_en. A new start after reset release completes normally.
